// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load and frame markers.
// Back-to-back words reload on the last bit for gapless streaming.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             flush,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             first_q, first_d;

    logic in_shift;
    logic last;
    logic accept;

    assign in_shift = (state_q == SHIFT);
    assign last     = in_shift && (cnt_q == '0);

    // flush must block a reload on the last bit, hence the input term
    assign load_ready = !in_shift || (last && !flush);
    assign accept     = load_valid && load_ready;

    assign serial_valid = in_shift;
    assign serial_out   = in_shift &&
                          (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign frame_start  = in_shift && first_q;
    assign done         = last;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        if (in_shift && flush) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            first_d = 1'b0;
        end else if (accept) begin
            state_d = SHIFT;
            shreg_d = parallel_in;
            cnt_d   = CW'(WIDTH - 1);
            first_d = 1'b1;
        end else if (in_shift) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            first_d = 1'b0;
            if (last) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: one MSB-first and one LSB-first instance
// share stimulus; a word-level model queues the expected serial cycles.
module tb_piso_tx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] parallel_in = '0;
    logic         flush = 1'b0;

    logic m_rdy, m_so, m_sv, m_fs, m_dn;
    logic l_rdy, l_so, l_sv, l_fs, l_dn;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid),
        .parallel_in(parallel_in), .flush(flush),
        .load_ready(m_rdy), .serial_out(m_so), .serial_valid(m_sv),
        .frame_start(m_fs), .done(m_dn)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid),
        .parallel_in(parallel_in), .flush(flush),
        .load_ready(l_rdy), .serial_out(l_so), .serial_valid(l_sv),
        .frame_start(l_fs), .done(l_dn)
    );

    typedef struct {
        logic         mb;
        logic         lb;
        logic         fs;
        logic         dn;
        logic [W-1:0] w;
    } exp_t;

    exp_t q[$];
    int   rem = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // One cycle of stimulus; the model advances at the rising edge.
    task automatic cyc(input logic lv, input logic [W-1:0] w,
                       input logic fl, output logic acc);
        logic rdy;
        load_valid  = lv;
        parallel_in = w;
        flush       = fl;
        @(posedge clk);
        rdy = (rem == 0) || (rem == 1 && !fl);
        acc = 1'b0;
        if (rem > 0 && fl) begin
            rem = 0;
            q.delete();
        end else if (lv && rdy) begin
            acc = 1'b1;
            rem = W;
            for (int i = 0; i < W; i++) begin
                exp_t e;
                e.mb = w[W-1-i];
                e.lb = w[i];
                e.fs = (i == 0);
                e.dn = (i == W - 1);
                e.w  = w;
                q.push_back(e);
            end
        end else if (rem > 0) begin
            rem--;
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) cyc(1'b0, '0, 1'b0, a);
    endtask

    task automatic check_reset_outs(input string nm);
        check({nm, "_m"}, {3'b0, m_rdy, m_so, m_sv, m_fs, m_dn}, 8'h10);
        check({nm, "_l"}, {3'b0, l_rdy, l_so, l_sv, l_fs, l_dn}, 8'h10);
    endtask

    // Monitor: pop one expected bit per serial_valid cycle.
    initial begin
        logic [W-1:0] rxm = '0;
        logic [W-1:0] rxl = '0;
        logic         er;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (rst) begin
                er = (rem == 0) || (rem == 1 && !flush);
                check("load_ready", {6'b0, m_rdy, l_rdy}, {6'b0, er, er});
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("valid", {6'b0, m_sv, l_sv}, 8'h03);
                    check("bit_msb", {7'b0, m_so}, {7'b0, e.mb});
                    check("bit_lsb", {7'b0, l_so}, {7'b0, e.lb});
                    check("frame_start", {6'b0, m_fs, l_fs},
                          {6'b0, e.fs, e.fs});
                    check("done", {6'b0, m_dn, l_dn}, {6'b0, e.dn, e.dn});
                    rxm = {rxm[W-2:0], m_so};
                    rxl = {l_so, rxl[W-1:1]};
                    if (e.dn) begin
                        check("rx_msb", {4'b0, rxm}, {4'b0, e.w});
                        check("rx_lsb", {4'b0, rxl}, {4'b0, e.w});
                    end
                end else begin
                    check("idle_msb", {4'b0, m_so, m_sv, m_fs, m_dn}, 8'h0);
                    check("idle_lsb", {4'b0, l_so, l_sv, l_fs, l_dn}, 8'h0);
                end
            end
        end
    end

    initial begin
        logic         a;
        logic         hold;
        logic         lv;
        logic         fl;
        logic [W-1:0] w;

        #2;
        check_reset_outs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // single word, then return to idle
        cyc(1'b1, 4'b1011, 1'b0, a);
        idle(6);

        // back-to-back: second word held until the done cycle
        cyc(1'b1, 4'b1011, 1'b0, a);
        repeat (W) cyc(1'b1, 4'b0110, 1'b0, a);
        idle(6);

        // asynchronous reset between edges during bit 2
        cyc(1'b1, 4'b1011, 1'b0, a);
        idle(1);
        #2;
        rst = 1'b0;
        rem = 0;
        q.delete();
        #1;
        check_reset_outs("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, 4'b0101, 1'b0, a);
        idle(6);

        // flush during bit 3 with load_valid high
        cyc(1'b1, 4'b1111, 1'b0, a);
        idle(2);
        cyc(1'b1, 4'b1010, 1'b1, a);
        check("flush_blocks_load", {7'b0, a}, 8'h0);
        cyc(1'b1, 4'b1010, 1'b0, a);
        check("load_after_flush", {7'b0, a}, 8'h1);
        idle(6);

        // load_valid pulsed while busy is ignored
        cyc(1'b1, 4'b1001, 1'b0, a);
        idle(1);
        cyc(1'b1, 4'b0111, 1'b0, a);
        cyc(1'b1, 4'b0111, 1'b0, a);
        idle(6);

        // random traffic; the source holds a word until it is taken
        hold = 1'b0;
        w    = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) w = W'($urandom);
            lv = hold || ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 15) == 0);
            cyc(lv, w, fl, a);
            hold = lv && !a;
        end
        idle(8);
        check("drain", 8'(q.size()), 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
